// File: rtl/awgn_pkg.sv
// Shared widths, SNR threshold table and FSM encoding for the AWGN SNR estimator.
package awgn_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int ERR_W      = SAMPLE_W + 1;
  localparam int SQ_W       = 2 * SAMPLE_W + 1;
  localparam int ACC_W      = 59;
  localparam int N_LOG2_DEF = 10;
  localparam int C_W        = 12;
  localparam int THR_W      = 57;
  localparam int PROD_W     = 61;
  localparam int DB_W       = 4;
  localparam int D_LAST     = 9;

  // 10^(d/10) in Q8, d = 0..9
  localparam logic [C_W-1:0] C_TBL [10] = '{
    12'd256, 12'd322, 12'd406, 12'd511, 12'd643,
    12'd810, 12'd1019, 12'd1283, 12'd1615, 12'd2033
  };

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCUM   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic [C_W-1:0] c_thr(input logic [DB_W-1:0] d);
    c_thr = '0;
    for (int i = 0; i < 10; i++) begin
      if (d == DB_W'(i)) c_thr = C_TBL[i];
    end
  endfunction

endpackage

// File: rtl/awgn_snr_estimator_if.sv
// Control, symbol stream and result signals of the SNR estimator.
interface awgn_snr_estimator_if;
  import awgn_pkg::*;

  logic                       start;
  logic [SAMPLE_W-1:0]        amp;
  logic                       y_valid;
  logic signed [SAMPLE_W-1:0] y_real;
  logic signed [SAMPLE_W-1:0] y_imag;
  logic                       y_ready;
  logic                       busy;
  logic                       est_valid;
  logic [SQ_W-1:0]            noise_pwr;
  logic [DB_W-1:0]            snr_db;
  logic                       snr_low;
  logic                       snr_sat;

  modport master (
    output start, amp, y_valid, y_real, y_imag,
    input  y_ready, busy, est_valid, noise_pwr, snr_db, snr_low, snr_sat
  );

  modport slave (
    input  start, amp, y_valid, y_real, y_imag,
    output y_ready, busy, est_valid, noise_pwr, snr_db, snr_low, snr_sat
  );

endinterface

// File: rtl/awgn_err_sq.sv
// QPSK hard-decision error followed by squared magnitude; two-cycle latency.
module awgn_err_sq
  import awgn_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic signed [SAMPLE_W-1:0] y_re_i,
  input  logic signed [SAMPLE_W-1:0] y_im_i,
  input  logic [SAMPLE_W-1:0]        amp_i,
  output logic [SQ_W-1:0]            sq_o,
  output logic                       sq_valid_o
);

  logic signed [ERR_W-1:0] amp_s;
  logic signed [ERR_W-1:0] y_re_s;
  logic signed [ERR_W-1:0] y_im_s;
  logic signed [ERR_W-1:0] e_re_d, e_re_q;
  logic signed [ERR_W-1:0] e_im_d, e_im_q;
  logic                    v1_q;
  logic [SQ_W-1:0]         sq_d, sq_q;
  logic                    v2_q;

  assign amp_s  = $signed({1'b0, amp_i});
  assign y_re_s = $signed({y_re_i[SAMPLE_W-1], y_re_i});
  assign y_im_s = $signed({y_im_i[SAMPLE_W-1], y_im_i});

  // decision is +A for y >= 0, -A for y < 0
  assign e_re_d = y_re_i[SAMPLE_W-1] ? (y_re_s + amp_s) : (y_re_s - amp_s);
  assign e_im_d = y_im_i[SAMPLE_W-1] ? (y_im_s + amp_s) : (y_im_s - amp_s);

  assign sq_d = SQ_W'(e_re_q * e_re_q) + SQ_W'(e_im_q * e_im_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_re_q <= '0;
      e_im_q <= '0;
      v1_q   <= 1'b0;
      sq_q   <= '0;
      v2_q   <= 1'b0;
    end else begin
      e_re_q <= e_re_d;
      e_im_q <= e_im_d;
      v1_q   <= valid_i;
      sq_q   <= sq_d;
      v2_q   <= v1_q;
    end
  end

  assign sq_o       = sq_q;
  assign sq_valid_o = v2_q;

endmodule

// File: rtl/awgn_snr_estimator.sv
// Windowed AWGN noise-power and SNR estimator for QPSK symbols.
// state      | meaning
// ST_IDLE    | waiting for start
// ST_ACCUM   | accepting symbols, accumulating squared error
// ST_DRAIN   | flushing the error/square/accumulate pipeline
// ST_COMPARE | testing d = 0..9 against the threshold table, one per cycle
// ST_DONE    | results valid and held until the next start
module awgn_snr_estimator
  import awgn_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
)
(
  input  logic                  clk,
  input  logic                  reset,
  awgn_snr_estimator_if.slave   bus
);

  localparam logic [1:0] DRAIN_LOAD = 2'd3;

  state_e              state_q;
  logic [SAMPLE_W-1:0] amp_q;
  logic [N_LOG2-1:0]   sym_cnt_q;
  logic [1:0]          drain_cnt_q;
  logic [DB_W-1:0]     d_q;
  logic [DB_W-1:0]     best_q;
  logic                any_q;
  logic                y_ready_q;
  logic                busy_q;
  logic                est_valid_q;
  logic [SQ_W-1:0]     noise_pwr_q;
  logic [DB_W-1:0]     snr_db_q;
  logic                snr_low_q;
  logic                snr_sat_q;
  logic [ACC_W-1:0]    acc_q;

  logic                accept;
  logic                start_acc;
  logic [SQ_W-1:0]     sq;
  logic                sq_valid;
  logic [2*SAMPLE_W-1:0] amp_sq;
  logic [THR_W-1:0]    thr;
  logic [PROD_W-1:0]   prod;
  logic                pass;

  assign accept    = bus.y_valid & y_ready_q;
  assign start_acc = bus.start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  awgn_err_sq u_err_sq (
    .clk        (clk),
    .rst_n      (reset),
    .valid_i    (accept),
    .y_re_i     (bus.y_real),
    .y_im_i     (bus.y_imag),
    .amp_i      (amp_q),
    .sq_o       (sq),
    .sq_valid_o (sq_valid)
  );

  // 2*A^2 in Q8 is A^2 shifted left by 9
  assign amp_sq = (2*SAMPLE_W)'(amp_q) * (2*SAMPLE_W)'(amp_q);
  assign thr    = {amp_sq, 9'd0};
  assign prod   = PROD_W'(noise_pwr_q) * PROD_W'(c_thr(d_q));
  assign pass   = (prod <= PROD_W'(thr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (start_acc) begin
      acc_q <= '0;
    end else if (sq_valid) begin
      acc_q <= acc_q + ACC_W'(sq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      amp_q       <= '0;
      sym_cnt_q   <= '0;
      drain_cnt_q <= '0;
      d_q         <= '0;
      best_q      <= '0;
      any_q       <= 1'b0;
      y_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      est_valid_q <= 1'b0;
      noise_pwr_q <= '0;
      snr_db_q    <= '0;
      snr_low_q   <= 1'b0;
      snr_sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q     <= ST_ACCUM;
            amp_q       <= bus.amp;
            sym_cnt_q   <= '1;
            y_ready_q   <= 1'b1;
            busy_q      <= 1'b1;
            est_valid_q <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            if (sym_cnt_q == '0) begin
              state_q     <= ST_DRAIN;
              y_ready_q   <= 1'b0;
              drain_cnt_q <= DRAIN_LOAD;
            end else begin
              sym_cnt_q <= sym_cnt_q - 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // the last square lands in the accumulator two edges after acceptance
          if (drain_cnt_q == '0) begin
            state_q     <= ST_COMPARE;
            noise_pwr_q <= SQ_W'(acc_q >> N_LOG2);
            d_q         <= '0;
            best_q      <= '0;
            any_q       <= 1'b0;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        ST_COMPARE: begin
          if (pass) begin
            best_q <= d_q;
            any_q  <= 1'b1;
          end
          if (d_q == DB_W'(D_LAST)) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            est_valid_q <= 1'b1;
            snr_db_q    <= pass ? d_q : best_q;
            snr_low_q   <= ~(pass | any_q);
            snr_sat_q   <= pass;
          end else begin
            d_q <= d_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.y_ready   = y_ready_q;
  assign bus.busy      = busy_q;
  assign bus.est_valid = est_valid_q;
  assign bus.noise_pwr = noise_pwr_q;
  assign bus.snr_db    = snr_db_q;
  assign bus.snr_low   = snr_low_q;
  assign bus.snr_sat   = snr_sat_q;

endmodule

// File: tb/tb_awgn_snr_estimator.sv
// Directed, table-driven bench for the AWGN SNR estimator.
module tb_awgn_snr_estimator;

  localparam int N_SYM = 1 << 10;

  typedef struct {
    logic [23:0]        amp;
    logic signed [23:0] yr;
    logic signed [23:0] yi;
    bit                 gaps;
    bit                 poke;
    longint             noise;
    int                 db;
    bit                 low;
    bit                 sat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs [9];

  awgn_snr_estimator_if bus();

  awgn_snr_estimator #(.N_LOG2(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_window(input logic [23:0] a, input logic signed [23:0] yr,
                            input logic signed [23:0] yi, input bit gaps, input bit poke,
                            input int stop_after, input string tag, output int lat);
    int acc_n;
    int guard;
    bit tog;
    bit will;
    lat = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.amp   = a;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_start_drop_est"}, longint'(bus.est_valid), 0);
    check({tag, "_start_busy"}, longint'(bus.busy), 1);
    bus.y_real = yr;
    bus.y_imag = yi;
    acc_n = 0;
    guard = 0;
    tog   = 1'b0;
    while (acc_n < stop_after && guard < 5000) begin
      bus.y_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      if (poke && acc_n == 100) begin
        bus.start = 1'b1;
        bus.amp   = 24'd5;
      end else begin
        bus.start = 1'b0;
      end
      will = bus.y_valid && bus.y_ready;
      @(negedge clk);
      if (will) acc_n++;
      guard++;
    end
    bus.y_valid = 1'b0;
    bus.start   = 1'b0;
    if (acc_n < stop_after) begin
      check({tag, "_accept_timeout"}, acc_n, stop_after);
    end else if (acc_n == N_SYM) begin
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk);
        #1;
        if (bus.est_valid) begin
          lat = k;
          break;
        end
      end
    end
  endtask

  task automatic check_result(input string tag, input int lat, input vec_t v);
    check({tag, "_latency"}, lat, 14);
    check({tag, "_noise_pwr"}, longint'(bus.noise_pwr), v.noise);
    check({tag, "_snr_db"}, longint'(bus.snr_db), longint'(v.db));
    check({tag, "_snr_low"}, longint'(bus.snr_low), longint'(v.low));
    check({tag, "_snr_sat"}, longint'(bus.snr_sat), longint'(v.sat));
    check({tag, "_busy_done"}, longint'(bus.busy), 0);
    check({tag, "_y_ready_done"}, longint'(bus.y_ready), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_y_ready"}, longint'(bus.y_ready), 0);
    check({tag, "_busy"}, longint'(bus.busy), 0);
    check({tag, "_est_valid"}, longint'(bus.est_valid), 0);
    check({tag, "_noise_pwr"}, longint'(bus.noise_pwr), 0);
    check({tag, "_snr_db"}, longint'(bus.snr_db), 0);
    check({tag, "_snr_low"}, longint'(bus.snr_low), 0);
    check({tag, "_snr_sat"}, longint'(bus.snr_sat), 0);
  endtask

  initial begin
    int lat;
    checks   = 0;
    failures = 0;
    rst_n       = 1'b1;
    bus.start   = 1'b0;
    bus.amp     = '0;
    bus.y_valid = 1'b0;
    bus.y_real  = '0;
    bus.y_imag  = '0;

    //          amp    yr     yi   gaps poke noise     db low sat
    vecs[0] = '{24'd1000,  24'sd1000,  24'sd1000, 0, 0, 0,       9, 0, 1};
    vecs[1] = '{24'd1000,  24'sd1500, -24'sd500,  0, 0, 500000,  6, 0, 0};
    vecs[2] = '{24'd1000,  24'sd3000, -24'sd3000, 0, 0, 8000000, 0, 1, 0};
    vecs[3] = '{24'd1000,  24'sd2000,  24'sd0,    0, 0, 2000000, 0, 0, 0};
    vecs[4] = '{24'd1000, -24'sd1700,  24'sd300,  0, 0, 980000,  3, 0, 0};
    vecs[5] = '{24'd0,     24'sd0,     24'sd0,    0, 0, 0,       9, 0, 1};
    vecs[6] = '{24'd0,     24'sd10,    24'sd0,    0, 0, 100,     0, 1, 0};
    vecs[7] = '{24'd1000,  24'sd1500, -24'sd500,  1, 0, 500000,  6, 0, 0};
    vecs[8] = '{24'd1000,  24'sd1500, -24'sd500,  0, 1, 500000,  6, 0, 0};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("por");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_window(vecs[i].amp, vecs[i].yr, vecs[i].yi, vecs[i].gaps, vecs[i].poke,
                 N_SYM, $sformatf("v%0d", i), lat);
      check_result($sformatf("v%0d", i), lat, vecs[i]);
    end

    // abort mid-window: outputs from the previous window must vanish immediately
    run_window(24'd1000, 24'sd1500, -24'sd500, 0, 0, 500, "abort", lat);
    check("abort_busy_before", longint'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check_zero("abort_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_window(24'd1000, 24'sd1500, -24'sd500, 0, 0, N_SYM, "fresh", lat);
    check_result("fresh", lat, vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
